// File: rtl/fifo_rd_stream_if.sv
// ============================================================================
// fifo_rd_stream_if : valid/ready stream carrying words out of the FIFO reader
// Revision: 1.0
// ============================================================================
`default_nettype none

interface fifo_rd_stream_if #(
   parameter int DSIZE = 8
);
   logic             valid;
   logic [DSIZE-1:0] data;
   logic             ready;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);
endinterface

`default_nettype wire

// File: rtl/fifo_rd_stream.sv
// ============================================================================
// fifo_rd_stream : FIFO pop port to registered valid/ready stream, 2-entry skid
// Revision: 1.0
// ============================================================================
`default_nettype none

module fifo_rd_stream #(
   parameter int DSIZE = 8,
   parameter int CSIZE = 16
) (
   input  wire logic             rclk,
   input  wire logic             rrst,
   input  wire logic             rempty,
   input  wire logic [DSIZE-1:0] rdata,
   output logic                  rinc,
   input  wire logic             flush,
   fifo_rd_stream_if.master      m,
   output logic [1:0]            level,
   output logic [CSIZE-1:0]      rd_cnt
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic             out_valid;
   logic [DSIZE-1:0] out_data;
   logic [DSIZE-1:0] skid;
   logic             skid_valid;
   logic             pop;
   logic             acc;
   logic             load_out_fifo;
   logic             load_out_skid;
   logic             load_skid;

   // Pop depends only on flops and FIFO flags, so m.ready never reaches rinc.
   assign rinc  = !rempty && !skid_valid && !flush && !rrst;
   assign pop   = rinc;
   assign acc   = out_valid && m.ready;
   assign level = state;

   assign m.valid = out_valid;
   assign m.data  = out_data;

   always_comb begin
      state_nxt     = state;
      load_out_fifo = 1'b0;
      load_out_skid = 1'b0;
      load_skid     = 1'b0;
      if (flush) begin
         state_nxt = EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (pop) begin
                  state_nxt     = ONE;
                  load_out_fifo = 1'b1;
               end
            end
            ONE: begin
               if (pop && acc) begin
                  load_out_fifo = 1'b1;
               end else if (pop) begin
                  state_nxt = TWO;
                  load_skid = 1'b1;
               end else if (acc) begin
                  state_nxt = EMPTY;
               end
            end
            TWO: begin
               if (acc) begin
                  state_nxt     = ONE;
                  load_out_skid = 1'b1;
               end
            end
            default: state_nxt = EMPTY;
         endcase
      end
   end

   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         state      <= EMPTY;
         out_valid  <= 1'b0;
         out_data   <= '0;
         skid       <= '0;
         skid_valid <= 1'b0;
         rd_cnt     <= '0;
      end else begin
         state      <= state_nxt;
         out_valid  <= (state_nxt != EMPTY);
         skid_valid <= (state_nxt == TWO);
         if (load_out_fifo) begin
            out_data <= rdata;
         end else if (load_out_skid) begin
            out_data <= skid;
         end
         if (load_skid) begin
            skid <= rdata;
         end
         // A transfer on the flush edge still happened downstream, so it counts.
         if (acc) begin
            rd_cnt <= rd_cnt + {{(CSIZE-1){1'b0}}, 1'b1};
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
// ============================================================================
// tb_fifo_rd_stream : directed + random bench with FIFO model and scoreboard
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fifo_rd_stream;

   logic        rclk   = 1'b0;
   logic        rrst   = 1'b1;
   logic        rempty = 1'b1;
   logic [7:0]  rdata  = 8'h00;
   logic        flush  = 1'b0;
   logic        rinc;
   logic        rinc4;
   logic [1:0]  level;
   logic [1:0]  level4;
   logic [15:0] rd_cnt;
   logic [3:0]  rd_cnt4;

   fifo_rd_stream_if #(.DSIZE(8)) s  ();
   fifo_rd_stream_if #(.DSIZE(8)) s4 ();
   assign s4.ready = s.ready;

   fifo_rd_stream #(.DSIZE(8), .CSIZE(16)) dut (
      .rclk(rclk), .rrst(rrst), .rempty(rempty), .rdata(rdata), .rinc(rinc),
      .flush(flush), .m(s), .level(level), .rd_cnt(rd_cnt)
   );

   fifo_rd_stream #(.DSIZE(8), .CSIZE(4)) dut4 (
      .rclk(rclk), .rrst(rrst), .rempty(rempty), .rdata(rdata), .rinc(rinc4),
      .flush(flush), .m(s4), .level(level4), .rd_cnt(rd_cnt4)
   );

   always #5 rclk = ~rclk;

   logic [7:0] fifo_q [$];
   logic [7:0] exp_q  [$];
   logic       pop_flag = 1'b0;
   int         n_assert = 0;
   int         n_fail   = 0;
   int         viol     = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] d);
      fifo_q.push_back(d);
      exp_q.push_back(d);
   endtask

   task automatic tick();
      @(posedge rclk);
      #1;
   endtask

   // Pop strobe as seen at the edge; rinc while empty is a protocol violation.
   initial forever begin
      @(posedge rclk);
      pop_flag = rinc;
      if (rinc && rempty) viol++;
   end

   // FIFO read side: flags and head word change between edges, like registered flags.
   initial forever begin
      @(negedge rclk);
      if (pop_flag) begin
         if (fifo_q.size() > 0) void'(fifo_q.pop_front());
         else viol++;
      end
      rempty = (fifo_q.size() == 0);
      if (!rempty) rdata = fifo_q[0];
   end

   // Scoreboard: a transfer is committed at the next edge, values are stable here.
   initial forever begin
      logic [7:0] e;
      @(negedge rclk);
      if (!rrst && s.valid && s.ready) begin
         e = (exp_q.size() > 0) ? exp_q.pop_front() : ~s.data;
         check("sb_data", {24'd0, s.data}, {24'd0, e});
      end
   end

   initial begin
      int pushed;
      int k;
      s.ready = 1'b0;

      // Reset and idle
      repeat (3) tick();
      check("rst_valid", s.valid, 0);
      check("rst_level", level, 0);
      check("rst_cnt", rd_cnt, 0);
      check("rst_rinc", rinc, 0);
      #2 rrst = 1'b0;
      tick();
      tick();
      check("idle_rinc", rinc, 0);
      check("idle_valid", s.valid, 0);

      // Streaming at full rate
      s.ready = 1'b1;
      push(8'h11); push(8'h22); push(8'h33);
      tick(); check("str_v0", s.valid, 1); check("str_d0", s.data, 8'h11);
      tick(); check("str_v1", s.valid, 1); check("str_d1", s.data, 8'h22);
      tick(); check("str_v2", s.valid, 1); check("str_d2", s.data, 8'h33);
      tick(); check("str_end_valid", s.valid, 0);
      check("str_cnt", rd_cnt, 3);

      // Backpressure: only two words leave the FIFO
      s.ready = 1'b0;
      push(8'h11); push(8'h22); push(8'h33); push(8'h44); push(8'h55);
      repeat (3) tick();
      check("bp_hold_d_a", s.data, 8'h11);
      repeat (3) tick();
      check("bp_level", level, 2);
      check("bp_rinc", rinc, 0);
      check("bp_hold_d", s.data, 8'h11);
      check("bp_hold_v", s.valid, 1);
      check("bp_pops", fifo_q.size(), 3);
      s.ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("bp_flow_v", s.valid, 1);
         check("bp_flow_d", s.data, 8'h22 + 8'h11 * 8'(i));
      end
      tick();
      check("bp_end_valid", s.valid, 0);
      check("bp_cnt", rd_cnt, 8);

      // Random backpressure with 1000 random words
      pushed = 0;
      k = 0;
      while ((pushed < 1000 || exp_q.size() != 0 || s.valid) && k < 20000) begin
         s.ready = 1'($urandom);
         if (pushed < 1000 && $urandom_range(1, 0) == 1) begin
            push(8'($urandom));
            pushed++;
         end
         tick();
         k++;
      end
      check("rnd_timeout", (k < 20000), 1);
      check("rnd_cnt", rd_cnt, 1008);
      check("rnd_cnt4", rd_cnt4, 1008 % 16);
      check("rnd_viol", viol, 0);

      // Flush while holding two words
      s.ready = 1'b0;
      push(8'hA0); push(8'hA1); push(8'hA2);
      repeat (4) tick();
      check("fl_pre_level", level, 2);
      flush = 1'b1;
      #1;
      check("fl_rinc", rinc, 0);
      tick();
      check("fl_level", level, 0);
      check("fl_valid", s.valid, 0);
      check("fl_data_kept", s.data, 8'hA0);
      check("fl_no_pop", fifo_q.size(), 1);
      flush = 1'b0;
      void'(exp_q.pop_front());
      void'(exp_q.pop_front());
      tick();
      check("fl_next_v", s.valid, 1);
      check("fl_next_d", s.data, 8'hA2);
      s.ready = 1'b1;
      tick();
      tick();
      check("fl_end_valid", s.valid, 0);
      check("fl_cnt", rd_cnt, 1009);

      // Asynchronous reset mid-operation
      s.ready = 1'b0;
      push(8'h01); push(8'h02); push(8'h03); push(8'h04);
      repeat (4) tick();
      #2 rrst = 1'b1;
      #1;
      check("ar_valid", s.valid, 0);
      check("ar_level", level, 0);
      check("ar_cnt", rd_cnt, 0);
      check("ar_cnt4", rd_cnt4, 0);
      check("ar_rinc", rinc, 0);
      fifo_q.delete();
      exp_q.delete();
      tick();
      rrst = 1'b0;

      // Counter wrap on the narrow instance
      s.ready = 1'b1;
      for (int i = 0; i < 17; i++) push(8'(i + 8'h40));
      k = 0;
      tick();
      while ((exp_q.size() != 0 || s.valid) && k < 200) begin
         tick();
         k++;
      end
      check("wr_timeout", (k < 200), 1);
      check("wr_cnt", rd_cnt, 17);
      check("wr_cnt4", rd_cnt4, 1);
      check("final_viol", viol, 0);
      check("final_sb_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
